mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, 4, consecutive cycles port 1 may be denied before forced grant (legal 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports pN_req  input  1  port N (N=0 pipeline MEM stage, N=1 loader/DMA) requests access; held until granted.
REQ-005 SHALL have ports pN_write  input  1  1=store, 0=load.
REQ-006 SHALL have ports pN_addr  input  64  byte address.
REQ-007 SHALL have ports pN_wdata  input  64  store data.
REQ-008 SHALL have ports pN_size  input  4  transfer size in bytes (1, 2, 4, 8).
REQ-009 SHALL have ports pN_gnt  output  1  request accepted this cycle.
REQ-010 SHALL have port p0_stall  output  1  pipeline stall, equals p0_req AND NOT p0_gnt.
REQ-011 SHALL have ports mem_address 64, mem_write_enable 1, mem_read_enable 1, mem_write_data 64, mem_xfer_size 4  output  drive data memory.
REQ-012 SHALL have port mem_read_data  input  64  data memory read result.
REQ-013 SHALL have ports rsp_valid 1, rsp_port 1, rsp_err 1, rsp_data 64  output  response for the previous cycle's grant.

Function
REQ-014 SHALL grant at most one port per cycle; pN_gnt combinational from current requests and registered state.
REQ-015 SHALL give port 0 priority over port 1, except as in REQ-017.
REQ-016 SHALL keep a starve counter: increments when p1_req=1 and p1_gnt=0; clears when p1_gnt=1 or p1_req=0; saturates at STARVE_LIMIT.
REQ-017 SHALL grant port 1 (denying port 0) in any cycle where counter==STARVE_LIMIT and p1_req=1.
REQ-018 SHALL drive mem_* combinationally from the granted port in the grant cycle; write commits at that cycle's posedge.
REQ-019 SHALL hold mem_write_enable, mem_read_enable, mem_address, mem_write_data, mem_xfer_size at 0 when no port is granted.
REQ-020 SHALL treat a request as misaligned/illegal if pN_size not in {1,2,4,8} or pN_addr mod pN_size != 0; such a request is granted (consumed) but memory enables stay 0.
REQ-021 SHALL, one cycle after any read grant or any illegal grant, assert rsp_valid for exactly one cycle with rsp_port=granted port; legal writes produce no response.
REQ-022 SHALL register rsp_data from mem_read_data at the grant-cycle posedge for legal reads; rsp_data=0 and rsp_err=1 for illegal requests.
REQ-023 SHALL support back-to-back grants every cycle (throughput 1/cycle); a new grant's issue overlaps the prior response cycle.
REQ-024 SHALL never assert pN_gnt when pN_req=0.

Reset
REQ-025 SHALL, while reset=1 at a posedge, clear starve counter, rsp_valid, rsp_port, rsp_err, rsp_data to 0.
REQ-026 SHALL force pN_gnt=0, p0_stall=0 and all mem_* outputs to 0 while reset=1.
REQ-027 SHALL drop any response pending when reset asserts; no rsp_valid in the cycle after reset deasserts.

Configuration
REQ-028 SHALL implement the starvation guard (REQ-016, REQ-017) only when MEM_ARB_STARVE_GUARD_EN is defined.
REQ-029 SHALL, without MEM_ARB_STARVE_GUARD_EN, use strict port-0 priority with no counter; STARVE_LIMIT is ignored.

Verification
REQ-030 SHALL cover: p0 load addr 0x10 size 8 alone -> p0_gnt same cycle, mem_read_enable=1, next cycle rsp_valid=1 rsp_port=0 rsp_data=memory[0x10].
REQ-031 SHALL cover: p0 store 0x20 data 0xDEAD size 8, then p1 load 0x20 -> p1 rsp_data=0xDEAD, no response for the store.
REQ-032 SHALL cover: p0_req and p1_req held high continuously, STARVE_LIMIT=4, guard enabled -> p1_gnt in 5th cycle, p0_stall=1 that cycle; guard disabled -> p1 never granted.
REQ-033 SHALL cover: p1 load addr 0x13 size 4 -> p1_gnt=1, mem enables 0, next cycle rsp_valid=1 rsp_err=1 rsp_data=0.
REQ-034 SHALL cover: reset asserted in cycle after a read grant -> rsp_valid stays 0, counter 0, all outputs 0.
REQ-035 SHALL cover: alternating p0/p1 read requests every cycle -> one grant per cycle, responses in grant order with correct rsp_port.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: port 0 (pipeline MEM) has priority over port 1 (loader/DMA).
// Define MEM_ARB_STARVE_GUARD_EN to force a port-1 grant after STARVE_LIMIT denied cycles.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_req,
    input  logic        p0_write,
    input  logic [63:0] p0_addr,
    input  logic [63:0] p0_wdata,
    input  logic [3:0]  p0_size,
    output logic        p0_gnt,
    output logic        p0_stall,

    input  logic        p1_req,
    input  logic        p1_write,
    input  logic [63:0] p1_addr,
    input  logic [63:0] p1_wdata,
    input  logic [3:0]  p1_size,
    output logic        p1_gnt,

    output logic [63:0] mem_address,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [63:0] mem_write_data,
    output logic [3:0]  mem_xfer_size,
    input  logic [63:0] mem_read_data,

    output logic        rsp_valid,
    output logic        rsp_port,
    output logic        rsp_err,
    output logic [63:0] rsp_data
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
        $error("STARVE_LIMIT must be in 1..15");
    end

    logic        force_p1;
    logic        any_gnt;
    logic        sel_write;
    logic [63:0] sel_addr;
    logic [63:0] sel_wdata;
    logic [3:0]  sel_size;
    logic        sel_legal;
    logic        issue;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_port_q, rsp_port_d;
    logic        rsp_err_q, rsp_err_d;
    logic [63:0] rsp_data_q, rsp_data_d;

    function automatic logic is_legal(input logic [2:0] addr_lo, input logic [3:0] size);
        case (size)
            4'd1:    is_legal = 1'b1;
            4'd2:    is_legal = (addr_lo[0] == 1'b0);
            4'd4:    is_legal = (addr_lo[1:0] == 2'b00);
            4'd8:    is_legal = (addr_lo == 3'b000);
            default: is_legal = 1'b0;
        endcase
    endfunction

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    assign force_p1 = (starve_q == 4'(STARVE_LIMIT));

    always_comb begin
        starve_d = '0;
        if (p1_req && !p1_gnt) begin
            starve_d = force_p1 ? starve_q : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_p1 = 1'b0;
`endif

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!reset) begin
            if (p1_req && force_p1) begin
                p1_gnt = 1'b1;
            end else if (p0_req) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
        end
    end

    assign p0_stall  = p0_req & ~p0_gnt & ~reset;
    assign any_gnt   = p0_gnt | p1_gnt;
    assign sel_write = p1_gnt ? p1_write : p0_write;
    assign sel_addr  = p1_gnt ? p1_addr  : p0_addr;
    assign sel_wdata = p1_gnt ? p1_wdata : p0_wdata;
    assign sel_size  = p1_gnt ? p1_size  : p0_size;
    assign sel_legal = is_legal(sel_addr[2:0], sel_size);
    // Illegal requests are consumed but never reach memory.
    assign issue     = any_gnt & sel_legal;

    always_comb begin
        mem_address      = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        mem_write_data   = '0;
        mem_xfer_size    = '0;
        if (issue) begin
            mem_address      = sel_addr;
            mem_write_enable = sel_write;
            mem_read_enable  = ~sel_write;
            mem_write_data   = sel_wdata;
            mem_xfer_size    = sel_size;
        end
    end

    always_comb begin
        rsp_valid_d = any_gnt & (~sel_legal | ~sel_write);
        rsp_port_d  = p1_gnt & rsp_valid_d;
        rsp_err_d   = any_gnt & ~sel_legal;
        rsp_data_d  = (issue && !sel_write) ? mem_read_data : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_port_q  <= rsp_port_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_port  = rsp_port_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

endmodule
